vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/VESA timing generator, successor to the fixed 640x480 controller. Derives a pixel-clock-enable from the 100 MHz system clock, produces sync, blanking and pixel coordinates for any mode set by parameters, with selectable sync polarity. Adds line/frame markers, a frame counter and an enable handshake that only starts or stops video on frame boundaries. Feeds the pixel-generation and colour-output logic.

Parameters:
CLK_DIV, 4, system clocks per pixel; legal range 1..16.
H_DISPLAY, 640, active pixels per line.
H_FRONT, 16, horizontal front porch in pixels.
H_SYNC, 96, horizontal sync width in pixels.
H_BACK, 48, horizontal back porch in pixels.
V_DISPLAY, 480, active lines per frame.
V_FRONT, 10, vertical front porch in lines.
V_SYNC, 2, vertical sync width in lines.
V_BACK, 33, vertical back porch in lines.
H_SYNC_POL, 0, active level of horizontal_sync (0 = active-low).
V_SYNC_POL, 0, active level of vertical_sync.
CNT_W, 11, coordinate counter width; must satisfy 2^CNT_W >= max(HTOTAL, VTOTAL).

Ports:
clock_at_100mhz  input  1  system clock
reset_button  input  1  asynchronous, active-high reset
enable  input  1  request video output; sampled only on p_tick
p_tick  output  1  one-clock pixel enable, once every CLK_DIV clocks
horizontal_sync  output  1  horizontal sync, polarity per H_SYNC_POL
vertical_sync  output  1  vertical sync, polarity per V_SYNC_POL
video_on  output  1  high while the current coordinate is in the active area
x_pixel  output  CNT_W  current horizontal position, 0..HTOTAL-1
y_pixel  output  CNT_W  current vertical position, 0..VTOTAL-1
line_start  output  1  one-clock pulse at x=0 while running
frame_start  output  1  one-clock pulse at x=0,y=0 while running
running  output  1  high in RUN and DRAIN states
frame_count  output  16  number of completed frames, wraps at 65535

Behaviour:
- Derived constants: HTOTAL is the sum of the four H parameters; VTOTAL is the sum of the four V parameters. Horizontal order is display, front porch, sync, back porch; vertical order is the same.
- Single clock domain, clock_at_100mhz. No logic is clocked by a derived clock; all pixel-rate logic uses the p_tick clock enable.
- Divider: div_cnt counts 0..CLK_DIV-1, free-running in every state. p_tick=1 when div_cnt==CLK_DIV-1. For CLK_DIV=1, p_tick is constantly 1.
- Reset (asynchronous) sets: div_cnt=0, x_pixel=0, y_pixel=0, state=IDLE, video_on=0, line_start=0, frame_start=0, running=0, frame_count=0, and both syncs at their inactive level (~POL).
- State machine, advancing only on p_tick:
  - IDLE: counters held at 0, video_on=0, syncs inactive. Go to RUN when enable=1.
  - RUN: counters advance. Go to DRAIN when enable=0.
  - DRAIN: counters advance. Go to RUN when enable=1. Go to IDLE on the last pixel (x=HTOTAL-1, y=VTOTAL-1) when enable=0.
- Counters on p_tick in RUN or DRAIN:
  - x increments; at x=HTOTAL-1, x wraps to 0 and y increments.
  - At y=VTOTAL-1 together with x=HTOTAL-1, y wraps to 0 and frame_count increments. frame_count also increments on the DRAIN-to-IDLE transition.
- All outputs are registered. Decode is computed from next-state counters, so sync, video_on and the markers change on the same edge as x_pixel/y_pixel (zero skew, zero latency relative to the coordinates).
- Sync windows:
  - horizontal_sync is active iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1.
  - vertical_sync is active iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1.
  - Both syncs are forced inactive in IDLE.
- video_on = (x < H_DISPLAY) && (y < V_DISPLAY) && state != IDLE.
- Markers: line_start and frame_start are high only in the p_tick clock where the displayed coordinate is x=0 (and y=0 for frame_start) and running=1. They are therefore asserted once per line/frame, not for CLK_DIV clocks.
- IDLE-to-RUN entry: on the entry tick the first displayed pixel is (0,0), frame_start=1 and line_start=1 in that clock.
- Reset mid-frame: immediate return to reset values. The first frame after release starts at (0,0) once enable is seen.
- enable toggling within a single frame never truncates a frame: the output is always whole frames.

Test Plan:
1. Defaults, enable=1 after reset: frame_start period = 800*525*4 = 1,680,000 clocks; line_start period = 3200 clocks; p_tick period = 4 clocks.
2. Defaults, sync windows: horizontal_sync low exactly for x=656..751 (384 clocks per line); vertical_sync low exactly for y=490..491; video_on high for x<640 and y<480 only, 307,200 p_ticks per frame.
3. enable dropped at y=100: frame completes to (799,524), then IDLE; syncs go high, video_on=0, running=0, frame_count increments by 1. Re-raising enable gives frame_start on the next p_tick.
4. enable deasserted then reasserted within the same frame (DRAIN then RUN): no gap; frame_start period remains 1,680,000 clocks.
5. Reset asserted mid-line at x=300 for 3 clocks: all outputs take reset values asynchronously; after release, first frame_start arrives 1 p_tick after enable is sampled.
6. Small mode: CLK_DIV=1, H=8/2/2/2, V=4/1/1/1, H_SYNC_POL=1. horizontal_sync is high for x=10..11; HTOTAL=14, VTOTAL=7; frame_count = 3 after 3*98 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA timing generator.
// Produces a pixel clock-enable from the system clock, plus registered sync,
// blanking, coordinates, line/frame markers and a frame counter. Video only
// starts or stops on frame boundaries.
//
// enable handshake: enable is a level request sampled only on p_tick. Raising
// it in IDLE starts a frame at (0,0) on that tick; dropping it while running
// lets the current frame finish and returns to IDLE after the last pixel.
// Re-raising it during that final frame resumes normal running with no gap.
module vga_timing_gen #(
    parameter int CLK_DIV    = 4,
    parameter int H_DISPLAY  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_DISPLAY  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int CNT_W      = 11
) (
    input  logic             clock_at_100mhz,
    input  logic             reset_button,
    input  logic             enable,
    output logic             p_tick,
    output logic             horizontal_sync,
    output logic             vertical_sync,
    output logic             video_on,
    output logic [CNT_W-1:0] x_pixel,
    output logic [CNT_W-1:0] y_pixel,
    output logic             line_start,
    output logic             frame_start,
    output logic             running,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0]       DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_FINAL  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_FINAL  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic             HS_ON     = (H_SYNC_POL != 0);
    localparam logic             VS_ON     = (V_SYNC_POL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       div_cnt;
    logic             last_pix;
    logic             active_next;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic [15:0]      fc_next;
    logic             hs_next;
    logic             vs_next;
    logic             video_next;
    logic             ls_next;
    logic             fs_next;

    assign p_tick   = (div_cnt == DIV_LAST);
    assign last_pix = (x_pixel == H_LAST) && (y_pixel == V_LAST);

    // Free-running pixel divider, counts 0..CLK_DIV-1 in every state.
    always_ff @(posedge clock_at_100mhz or posedge reset_button) begin
        if (reset_button)
            div_cnt <= '0;
        else if (div_cnt == DIV_LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 4'd1;
    end

    // State register.
    always_ff @(posedge clock_at_100mhz or posedge reset_button) begin
        if (reset_button)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; transitions only on pixel ticks.
    always_comb begin
        state_next = state;
        if (p_tick) begin
            case (state)
                IDLE:    if (enable) state_next = RUN;
                RUN:     if (!enable) state_next = DRAIN;
                DRAIN: begin
                    if (enable)
                        state_next = RUN;
                    else if (last_pix)
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Next coordinates and decode from them, so outputs have zero skew to x/y.
    always_comb begin
        x_next  = x_pixel;
        y_next  = y_pixel;
        fc_next = frame_count;
        if (p_tick) begin
            if (state == IDLE || state_next == IDLE) begin
                x_next = '0;
                y_next = '0;
                if (state == DRAIN && state_next == IDLE)
                    fc_next = frame_count + 16'd1;
            end else if (x_pixel == H_LAST) begin
                x_next = '0;
                if (y_pixel == V_LAST) begin
                    y_next  = '0;
                    fc_next = frame_count + 16'd1;
                end else begin
                    y_next = y_pixel + CNT_W'(1);
                end
            end else begin
                x_next = x_pixel + CNT_W'(1);
            end
        end
        active_next = (state_next != IDLE);
        hs_next     = (active_next && x_next >= HS_FIRST && x_next <= HS_FINAL) ? HS_ON : ~HS_ON;
        vs_next     = (active_next && y_next >= VS_FIRST && y_next <= VS_FINAL) ? VS_ON : ~VS_ON;
        video_next  = active_next && (x_next < H_ACT) && (y_next < V_ACT);
        ls_next     = p_tick && active_next && (x_next == '0);
        fs_next     = ls_next && (y_next == '0);
    end

    // Registered outputs.
    always_ff @(posedge clock_at_100mhz or posedge reset_button) begin
        if (reset_button) begin
            x_pixel         <= '0;
            y_pixel         <= '0;
            frame_count     <= '0;
            horizontal_sync <= ~HS_ON;
            vertical_sync   <= ~VS_ON;
            video_on        <= 1'b0;
            line_start      <= 1'b0;
            frame_start     <= 1'b0;
            running         <= 1'b0;
        end else begin
            x_pixel         <= x_next;
            y_pixel         <= y_next;
            frame_count     <= fc_next;
            horizontal_sync <= hs_next;
            vertical_sync   <= vs_next;
            video_on        <= video_next;
            line_start      <= ls_next;
            frame_start     <= fs_next;
            running         <= active_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small mode: CLK_DIV=3, H=8/2/2/2 (HTOTAL=14),
// V=4/1/1/1 (VTOTAL=7), horizontal sync active-high, vertical active-low.
// Driver issues one enable value per pixel tick and pushes the expected
// registered outputs; a monitor pops and compares after every DUT tick.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        p_tick;
    logic        horizontal_sync;
    logic        vertical_sync;
    logic        video_on;
    logic [10:0] x_pixel;
    logic [10:0] y_pixel;
    logic        line_start;
    logic        frame_start;
    logic        running;
    logic [15:0] frame_count;

    // Clock and DUT.
    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1), .V_SYNC_POL(0), .CNT_W(11)
    ) dut (
        .clock_at_100mhz(clk),
        .reset_button(rst),
        .enable(enable),
        .p_tick(p_tick),
        .horizontal_sync(horizontal_sync),
        .vertical_sync(vertical_sync),
        .video_on(video_on),
        .x_pixel(x_pixel),
        .y_pixel(y_pixel),
        .line_start(line_start),
        .frame_start(frame_start),
        .running(running),
        .frame_count(frame_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [43:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] pack(input logic r, input logic v, input logic hs,
                                         input logic vs, input logic ls, input logic fs,
                                         input logic [10:0] x, input logic [10:0] y,
                                         input logic [15:0] fc);
        return {r, v, hs, vs, ls, fs, x, y, fc};
    endfunction

    function automatic logic [43:0] dut_vec();
        return pack(running, video_on, horizontal_sync, vertical_sync, line_start,
                    frame_start, x_pixel, y_pixel, frame_count);
    endfunction

    // Raster model: 0 idle, 1 run, 2 drain.
    int          m_st = 0;
    int          m_x  = 0;
    int          m_y  = 0;
    logic [15:0] m_fc = '0;

    task automatic model_reset();
        m_st = 0; m_x = 0; m_y = 0; m_fc = '0;
    endtask

    // Driver: one pixel tick with the given enable level; returns 2 ns after the tick edge.
    task automatic step(input logic e);
        logic r, v, hs, vs, ls, fs;
        enable = e;
        if (m_st == 0) begin
            if (e) begin m_st = 1; m_x = 0; m_y = 0; end
        end else if (m_st == 2 && !e && m_x == 13 && m_y == 6) begin
            m_st = 0; m_x = 0; m_y = 0; m_fc = m_fc + 16'd1;
        end else begin
            if (m_x == 13) begin
                m_x = 0;
                if (m_y == 6) begin m_y = 0; m_fc = m_fc + 16'd1; end
                else m_y = m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
            m_st = e ? 1 : 2;
        end
        r  = (m_st != 0);
        v  = r && m_x < 8 && m_y < 4;
        hs = r && (m_x == 10 || m_x == 11);
        vs = !(r && m_y == 5);
        ls = r && m_x == 0;
        fs = ls && m_y == 0;
        exp_q.push_back(pack(r, v, hs, vs, ls, fs, 11'(m_x), 11'(m_y), m_fc));
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic steps(input logic e, input int n);
        for (int i = 0; i < n; i++) step(e);
    endtask

    // Monitor: tick arming and p_tick spacing sampled on the falling edge.
    logic tick_seen = 1'b0;
    int   gap       = 0;
    bit   gap_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            tick_seen = 1'b0;
            gap_valid = 1'b0;
            gap       = 0;
        end else begin
            gap++;
            if (p_tick) begin
                if (gap_valid) check("p_tick_period", 64'(gap), 64'd3);
                gap       = 0;
                gap_valid = 1'b1;
            end
            tick_seen = p_tick;
        end
    end

    // Scoreboard: compare 1 ns after each tick edge; markers must be low otherwise.
    int     hs_cnt = 0;
    int     vid_cnt = 0;
    longint cyc = 0;
    longint fs_times[$];
    always @(posedge clk) begin
        logic armed;
        logic [43:0] e;
        armed = tick_seen;
        cyc++;
        #1;
        if (armed) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", 64'(dut_vec()), 64'h0FFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 64'(dut_vec()), 64'(e));
            end
            if (horizontal_sync) hs_cnt++;
            if (video_on) vid_cnt++;
            if (frame_start) fs_times.push_back(cyc);
        end else begin
            check("marker_between_ticks", {62'd0, line_start, frame_start}, 64'd0);
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(dut_vec()), 64'(pack(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        check("reset_p_tick", 64'(p_tick), 64'd0);
        rst = 1'b0;

        // Idle with enable low.
        steps(1'b0, 3);
        check("idle_running", 64'(running), 64'd0);

        // Three whole frames plus entry into the fourth.
        hs_cnt = 0; vid_cnt = 0;
        steps(1'b1, 295);
        check("frame_count_3", 64'(frame_count), 64'd3);
        check("pos_after_3_frames", {42'd0, x_pixel, y_pixel}, 64'd0);
        check("hsync_ticks_3_frames", 64'(hs_cnt), 64'd42);
        check("video_ticks_3_frames", 64'(vid_cnt), 64'd97);

        // Drop enable at y=3: frame completes, then IDLE.
        steps(1'b1, 42);
        check("pos_y3", {42'd0, x_pixel, y_pixel}, {42'd0, 11'd0, 11'd3});
        steps(1'b0, 58);
        check("drain_idle_running", 64'(running), 64'd0);
        check("drain_frame_count", 64'(frame_count), 64'd4);
        check("drain_syncs", {62'd0, horizontal_sync, vertical_sync}, 64'd1);
        check("drain_video", 64'(video_on), 64'd0);

        // Re-enable: frame_start on the first tick, then a DRAIN/RUN toggle mid-frame.
        fs_times.delete();
        step(1'b1);
        check("restart_markers", {62'd0, line_start, frame_start}, 64'd3);
        steps(1'b1, 19);
        steps(1'b0, 10);
        steps(1'b1, 196);
        check("fs_count_toggle", 64'(fs_times.size()), 64'd3);
        if (fs_times.size() == 3) begin
            check("fs_period_toggle", 64'(fs_times[1] - fs_times[0]), 64'd294);
            check("fs_period_run", 64'(fs_times[2] - fs_times[1]), 64'd294);
        end

        // Reset mid-line at x=5.
        steps(1'b1, 4);
        check("pos_before_reset", {42'd0, x_pixel, y_pixel}, {42'd0, 11'd5, 11'd2});
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'(dut_vec()), 64'(pack(0, 0, 0, 1, 0, 0, 0, 0, 0)));
        check("queue_drained_at_reset", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        steps(1'b0, 2);
        step(1'b1);
        check("post_reset_start", {60'd0, line_start, frame_start, running, video_on}, 64'hF);
        steps(1'b1, 20);

        check("queue_empty_end", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
